mul32acc_seq: RTL

Sequential shift-add multiply-accumulator computing p = a*b + c. It is the inverse of the team's pipelined divider: given quotient q, divisor d and remainder r, it rebuilds the dividend x = q*d + r. It is used for divider self-checking and for datapaths that need an exact 2K-bit product at low area. Operands enter and results leave through valid/ready handshakes. The block holds one operation in flight.

---
 rtl/mul32acc_seq_if.sv | 26 ++
 rtl/mul32acc_seq.sv | 95 +++++++++
 2 files changed

// File: rtl/mul32acc_seq_if.sv
// rtl/mul32acc_seq_if.sv - operand/result handshake bundle for mul32acc_seq
interface mul32acc_seq_if #(
  parameter int K = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [K-1:0]   a;
  logic [K-1:0]   b;
  logic [K-1:0]   c;
  logic           out_valid;
  logic           out_ready;
  logic [2*K-1:0] p;
  logic           busy;

  // Producer/consumer side: offers operands and takes results
  modport master (
    output in_valid, a, b, c, out_ready,
    input  in_ready, out_valid, p, busy
  );

  // Multiplier side
  modport slave (
    input  in_valid, a, b, c, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/mul32acc_seq.sv
// rtl/mul32acc_seq.sv - shift-add multiply-accumulate p = a*b + c; optional MULACC_EARLY_EXIT_EN
module mul32acc_seq #(
  parameter int K = 32
) (
  input  logic           clk,
  input  logic           rstn,
  mul32acc_seq_if.slave  bus
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_rst_done;
  logic [2*K-1:0] r_acc;
  logic [2*K-1:0] r_mcand;
  logic [2*K-1:0] r_p;
  logic [K-1:0]   r_mult;
  logic [CW-1:0]  r_cnt;
  logic [2*K-1:0] w_acc_nxt;
  logic           w_accept;
  logic           w_last;

  // in_ready stays low until the first edge after reset release
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.in_ready  = (r_state == S_IDLE) && r_rst_done;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_BUSY);
  assign bus.p         = r_p;

  assign w_acc_nxt = r_mult[0] ? (r_acc + r_mcand) : r_acc;

`ifdef MULACC_EARLY_EXIT_EN
  // Stop as soon as no set multiplier bits remain after this iteration's shift
  assign w_last = (r_cnt == LAST_ITER) || (r_mult[K-1:1] == '0);
`else
  assign w_last = (r_cnt == LAST_ITER);
`endif

  // State register and reset-release tracker
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_done <= 1'b1;
    end
  end

  // Next-state selection
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept)      w_state_nxt = S_BUSY;
      S_BUSY: if (w_last)        w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, one shift-add per BUSY edge, capture p on the final one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mult  <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        r_acc   <= {{K{1'b0}}, bus.c};
        r_mcand <= {{K{1'b0}}, bus.a};
        r_mult  <= bus.b;
        r_cnt   <= '0;
      end
    end else if (r_state == S_BUSY) begin
      r_acc   <= w_acc_nxt;
      r_mcand <= {r_mcand[2*K-2:0], 1'b0};
      r_mult  <= {1'b0, r_mult[K-1:1]};
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_p <= w_acc_nxt;
      end
    end
  end

endmodule
